// File: rtl/s_axi_lite_arbiter.sv
// Two-requester AXI4-Lite register master: round-robin grant, one outstanding
// single-beat read or write, one response pulse back to the granted requester.
module s_axi_lite_arbiter #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    axi_aclk,
  input  logic                    axi_reset,
  // requester side
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [1:0]              req_write,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [2*DATA_WIDTH-1:0] req_wdata,
  output logic [1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  // AXI-Lite write channels
  output logic                    s_axi_lite_awvalid,
  input  logic                    s_axi_lite_awready,
  output logic [ADDR_WIDTH-1:0]   s_axi_lite_awaddr,
  output logic                    s_axi_lite_wvalid,
  input  logic                    s_axi_lite_wready,
  output logic [DATA_WIDTH-1:0]   s_axi_lite_wdata,
  input  logic                    s_axi_lite_bvalid,
  output logic                    s_axi_lite_bready,
  input  logic [1:0]              s_axi_lite_bresp,
  // AXI-Lite read channels
  output logic                    s_axi_lite_arvalid,
  input  logic                    s_axi_lite_arready,
  output logic [ADDR_WIDTH-1:0]   s_axi_lite_araddr,
  input  logic                    s_axi_lite_rvalid,
  output logic                    s_axi_lite_rready,
  input  logic [DATA_WIDTH-1:0]   s_axi_lite_rdata,
  input  logic [1:0]              s_axi_lite_rresp
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_WR_RESP, S_RD_ADDR, S_RD_DATA, S_RESP
  } state_t;

  state_t                  state, state_nxt;
  logic                    last_grant, grant_q, gnt_idx, take;
  logic                    aw_done, w_done, aw_hs, w_hs;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q, rdata_q;
  logic [1:0]              resp_q;

  // On a tie the requester that did not win last time is granted.
  assign gnt_idx   = (req_valid == 2'b11) ? ~last_grant : req_valid[1];
  assign take      = (state == S_IDLE) && (|req_valid);
  assign req_ready = take ? (gnt_idx ? 2'b10 : 2'b01) : 2'b00;

  // Valids are decoded from registered state so an async reset drops them at once.
  assign s_axi_lite_awvalid = (state == S_WR) && !aw_done;
  assign s_axi_lite_wvalid  = (state == S_WR) && !w_done;
  assign s_axi_lite_bready  = (state == S_WR_RESP);
  assign s_axi_lite_arvalid = (state == S_RD_ADDR);
  assign s_axi_lite_rready  = (state == S_RD_DATA);
  assign s_axi_lite_awaddr  = addr_q;
  assign s_axi_lite_araddr  = addr_q;
  assign s_axi_lite_wdata   = wdata_q;

  assign aw_hs = s_axi_lite_awvalid && s_axi_lite_awready;
  assign w_hs  = s_axi_lite_wvalid && s_axi_lite_wready;

  assign rsp_valid = (state == S_RESP) ? (grant_q ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_rdata = rdata_q;
  assign rsp_resp  = resp_q;

  always_comb begin
    // NOTE: default assigned first so no path through the case infers a latch.
    state_nxt = state;
    case (state)
      S_IDLE:    if (take) state_nxt = req_write[gnt_idx] ? S_WR : S_RD_ADDR;
      S_WR:      if ((aw_done || aw_hs) && (w_done || w_hs)) state_nxt = S_WR_RESP;
      S_WR_RESP: if (s_axi_lite_bvalid) state_nxt = S_RESP;
      S_RD_ADDR: if (s_axi_lite_arready) state_nxt = S_RD_DATA;
      S_RD_DATA: if (s_axi_lite_rvalid) state_nxt = S_RESP;
      S_RESP:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments keep every register update order-independent.
  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset) begin
      state      <= S_IDLE;
      last_grant <= 1'b1;
      grant_q    <= 1'b0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      resp_q     <= 2'b00;
    end else begin
      state <= state_nxt;
      if (take) begin
        last_grant <= gnt_idx;
        grant_q    <= gnt_idx;
        aw_done    <= 1'b0;
        w_done     <= 1'b0;
        addr_q     <= gnt_idx ? req_addr[ADDR_WIDTH +: ADDR_WIDTH]
                              : req_addr[0 +: ADDR_WIDTH];
        if (req_write[gnt_idx])
          wdata_q <= gnt_idx ? req_wdata[DATA_WIDTH +: DATA_WIDTH]
                             : req_wdata[0 +: DATA_WIDTH];
      end
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs)  w_done  <= 1'b1;
      if (state == S_WR_RESP && s_axi_lite_bvalid) begin
        rdata_q <= '0;
        resp_q  <= s_axi_lite_bresp;
      end
      if (state == S_RD_DATA && s_axi_lite_rvalid) begin
        rdata_q <= s_axi_lite_rdata;
        resp_q  <= s_axi_lite_rresp;
      end
    end
  end

endmodule
